frame_pattern_gen: RTL and testbench

//  Downstream stage of the frame timing generator. Consumes fval/lval/dval, tracks pixel (x) and

---
 rtl/frame_gen_pkg.sv | 18 +
 rtl/frame_pattern_gen_edge_detect.sv | 27 ++
 rtl/frame_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_frame_pattern_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_gen_pkg.sv
// Shared constants and elaboration-time helpers for the frame pattern generator.
package frame_gen_pkg;

  localparam int COORD_W = 16;

  localparam logic [1:0] PAT_HGRAD = 2'd0;
  localparam logic [1:0] PAT_VGRAD = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Evenly spaced bar level from 0 to full scale; only ever evaluated as a constant.
  function automatic logic [63:0] bar_level(input int idx, input int count, input int width);
    logic [63:0] full;
    full = (64'd1 << width) - 64'd1;
    return (64'(idx) * full) / 64'(count - 1);
  endfunction

endpackage

// File: rtl/frame_pattern_gen_edge_detect.sv
// Single-bit edge detector: registers the input and flags rising/falling transitions.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic primed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= sig_i;
      primed_q <= 1'b1;
    end
  end

  // No edges until one real sample exists, so a level already high at reset release is not a rise.
  assign rise_o = primed_q & sig_i & ~prev_q;
  assign fall_o = primed_q & ~sig_i & prev_q;

endmodule

// File: rtl/frame_pattern_gen.sv
// Tracks pixel/line coordinates from fval/lval/dval, emits a test pattern one cycle later,
// and keeps sticky geometry and protocol error flags.
module frame_pattern_gen
  import frame_gen_pkg::*;
#(
  parameter int PIX_WIDTH   = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BAR_COUNT   = 8,
  parameter int CHECK_SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fval_in,
  input  logic                 lval_in,
  input  logic                 dval_in,
  input  logic [1:0]           pattern_sel,
  input  logic                 err_clr,
  output logic                 fval_out,
  output logic                 lval_out,
  output logic                 dval_out,
  output logic [PIX_WIDTH-1:0] pixel_out,
  output logic [COORD_W-1:0]   x_out,
  output logic [COORD_W-1:0]   y_out,
  output logic [COORD_W-1:0]   frame_cnt,
  output logic                 line_err,
  output logic                 frame_err,
  output logic                 protocol_err
);

  localparam int BAR_W  = H_ACTIVE / BAR_COUNT;
  localparam int BCNT_W = $clog2(BAR_W + 1);
  localparam int BIDX_W = $clog2(BAR_COUNT);

  localparam logic [BCNT_W-1:0]  BAR_LAST = BCNT_W'(BAR_W - 1);
  localparam logic [BIDX_W-1:0]  BAR_MAX  = BIDX_W'(BAR_COUNT - 1);
  localparam logic [COORD_W-1:0] H_EXP    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_EXP    = COORD_W'(V_ACTIVE);

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == '1) ? v : v + COORD_W'(1);
  endfunction

  logic [PIX_WIDTH-1:0] bar_lut [BAR_COUNT];

  for (genvar g = 0; g < BAR_COUNT; g++) begin : g_bar_lut
    localparam logic [63:0] LVL = bar_level(g, BAR_COUNT, PIX_WIDTH);
    assign bar_lut[g] = LVL[PIX_WIDTH-1:0];
  end

  // Line edges are qualified by fval so that a frame end also closes any open line.
  logic lval_gated;
  logic fval_rise, fval_fall, lval_rise, lval_fall;

  assign lval_gated = lval_in & fval_in;

  edge_detect u_fval_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (fval_in),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  edge_detect u_lval_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (lval_gated),
    .rise_o (lval_rise),
    .fall_o (lval_fall)
  );

  logic                 armed_q, armed_d;
  logic [1:0]           pat_q, pat_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [COORD_W-1:0]   fcnt_q, fcnt_d;
  logic                 line_err_q, line_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 proto_err_q, proto_err_d;
  logic                 fval_out_q, fval_out_d;
  logic                 lval_out_q, lval_out_d;
  logic                 dval_out_q, dval_out_d;
  logic [PIX_WIDTH-1:0] pix_q, pix_d;
  logic [COORD_W-1:0]   x_out_q, x_out_d;
  logic [COORD_W-1:0]   y_out_q, y_out_d;

  logic                 armed_eff;
  logic [1:0]           pat_eff;
  logic [COORD_W-1:0]   x_eff, y_eff;
  logic [BCNT_W-1:0]    bcnt_eff;
  logic [BIDX_W-1:0]    bidx_eff;
  logic                 pix_v, proto_ev, line_end, frame_end;
  logic                 line_set, frame_set;
  logic [PIX_WIDTH-1:0] pattern;

  always_comb begin
    // Same-cycle frame/line starts take effect on the pixel presented in that cycle.
    armed_eff = armed_q | fval_rise;
    pat_eff   = fval_rise ? pattern_sel : pat_q;
    y_eff     = fval_rise ? '0 : y_q;
    x_eff     = lval_rise ? '0 : x_q;
    bcnt_eff  = lval_rise ? '0 : bcnt_q;
    bidx_eff  = lval_rise ? '0 : bidx_q;

    pix_v     = armed_eff & dval_in & lval_in & fval_in;
    proto_ev  = armed_eff & ((dval_in & ~lval_in) | (lval_in & ~fval_in));
    line_end  = armed_q & lval_fall;
    frame_end = armed_q & fval_fall;

    armed_d = armed_eff;
    pat_d   = pat_eff;
    x_d     = x_eff;
    bcnt_d  = bcnt_eff;
    bidx_d  = bidx_eff;
    if (pix_v) begin
      x_d = sat_inc(x_eff);
      if (bcnt_eff == BAR_LAST) begin
        bcnt_d = '0;
        if (bidx_eff != BAR_MAX) bidx_d = bidx_eff + BIDX_W'(1);
      end else begin
        bcnt_d = bcnt_eff + BCNT_W'(1);
      end
    end

    // x equals the line's valid-pixel count once the line has closed.
    y_d = y_eff;
    if (line_end && x_eff != '0) y_d = sat_inc(y_eff);
    line_set  = line_end & (x_eff != H_EXP);
    frame_set = frame_end & (y_d != V_EXP);
    fcnt_d    = frame_end ? fcnt_q + COORD_W'(1) : fcnt_q;

    line_err_d  = line_set | (line_err_q & ~err_clr);
    frame_err_d = frame_set | (frame_err_q & ~err_clr);
    proto_err_d = proto_ev | (proto_err_q & ~err_clr);

    pattern = '0;
    case (pat_eff)
      PAT_HGRAD: pattern = PIX_WIDTH'(x_eff + fcnt_q);
      PAT_VGRAD: pattern = PIX_WIDTH'(y_eff);
      PAT_BARS:  pattern = bar_lut[bidx_eff];
      PAT_CHECK: pattern = {PIX_WIDTH{x_eff[CHECK_SHIFT] ^ y_eff[CHECK_SHIFT]}};
      default:   pattern = '0;
    endcase

    fval_out_d = armed_eff & fval_in;
    lval_out_d = armed_eff & lval_in & fval_in;
    dval_out_d = pix_v;
    pix_d      = pix_v ? pattern : '0;
    x_out_d    = armed_eff ? x_eff : '0;
    y_out_d    = armed_eff ? y_eff : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      pat_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bcnt_q      <= '0;
      bidx_q      <= '0;
      fcnt_q      <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      proto_err_q <= 1'b0;
      fval_out_q  <= 1'b0;
      lval_out_q  <= 1'b0;
      dval_out_q  <= 1'b0;
      pix_q       <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else begin
      armed_q     <= armed_d;
      pat_q       <= pat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bcnt_q      <= bcnt_d;
      bidx_q      <= bidx_d;
      fcnt_q      <= fcnt_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      proto_err_q <= proto_err_d;
      fval_out_q  <= fval_out_d;
      lval_out_q  <= lval_out_d;
      dval_out_q  <= dval_out_d;
      pix_q       <= pix_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign fval_out     = fval_out_q;
  assign lval_out     = lval_out_q;
  assign dval_out     = dval_out_q;
  assign pixel_out    = pix_q;
  assign x_out        = x_out_q;
  assign y_out        = y_out_q;
  assign frame_cnt    = fcnt_q;
  assign line_err     = line_err_q;
  assign frame_err    = frame_err_q;
  assign protocol_err = proto_err_q;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Randomized-gap frame stimulus for frame_pattern_gen, checked against pattern formulas
// evaluated from frame/line/pixel indices.
module tb_frame_pattern_gen;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int PW = 8;
  localparam int CS = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fval_in, lval_in, dval_in, err_clr;
  logic [1:0]    pattern_sel;
  logic          fval_out, lval_out, dval_out;
  logic [PW-1:0] pixel_out;
  logic [15:0]   x_out, y_out, frame_cnt;
  logic          line_err, frame_err, protocol_err;

  int checks = 0;
  int errors = 0;

  frame_pattern_gen #(
    .PIX_WIDTH(PW), .H_ACTIVE(H), .V_ACTIVE(V), .BAR_COUNT(B), .CHECK_SHIFT(CS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fval_in(fval_in), .lval_in(lval_in), .dval_in(dval_in),
    .pattern_sel(pattern_sel), .err_clr(err_clr), .fval_out(fval_out), .lval_out(lval_out),
    .dval_out(dval_out), .pixel_out(pixel_out), .x_out(x_out), .y_out(y_out),
    .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ev;
    int          ex, ey, ef, es;
    logic        av, af, al;
    logic [7:0]  ap;
    logic [15:0] ax, ay;
  } rec_t;

  rec_t recs[$];
  int   cur_y   = 0;
  int   exp_fc  = 0;
  int   exp_sel = 0;
  bit   clr_on_fall = 1'b0;

  // Expected pixel from the pattern rules, given column, row and completed-frame count.
  function automatic logic [7:0] exp_pixel(input int s, input int x, input int y, input int f);
    int b;
    case (s)
      0: return 8'((x + f) % 256);
      1: return 8'(y % 256);
      2: begin
        b = x / (H / B);
        if (b > B - 1) b = B - 1;
        return 8'(b * 255 / (B - 1));
      end
      default: return (((x >> CS) + (y >> CS)) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic tick(input bit f, input bit l, input bit d, input bit v, input int ex);
    rec_t r;
    fval_in = f; lval_in = l; dval_in = d;
    @(posedge clk); #1;
    r.ev = v; r.ex = ex; r.ey = cur_y; r.ef = exp_fc; r.es = exp_sel;
    r.av = dval_out; r.af = fval_out; r.al = lval_out; r.ap = pixel_out;
    r.ax = x_out; r.ay = y_out;
    recs.push_back(r);
  endtask

  task automatic frame_begin(input bit lead);
    exp_sel = int'(pattern_sel);
    cur_y = 0;
    if (lead) tick(1, 0, 0, 0, 0);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) tick(1, 1, 0, 0, 0);
      tick(1, 1, 1, 1, i);
    end
    if (n == 0) tick(1, 1, 0, 0, 0);
    err_clr = clr_on_fall;
    tick(1, 0, 0, 0, 0);
    err_clr = 1'b0;
    if (n > 0) cur_y++;
  endtask

  task automatic frame_end();
    tick(0, 0, 0, 0, 0);
    exp_fc = (exp_fc + 1) % 65536;
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic clear_pulse();
    err_clr = 1'b1;
    tick(0, 0, 0, 0, 0);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fval_in = 0; lval_in = 0; dval_in = 0; err_clr = 0; pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fval_out, lval_out, dval_out, pixel_out, x_out, y_out} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {fval_out, lval_out, dval_out, pixel_out, x_out, y_out});
    end
    checks++;
    if ({frame_cnt, line_err, frame_err, protocol_err} !== '0) begin
      errors++; $display("FAIL reset_status got %h want 0", {frame_cnt, line_err, frame_err, protocol_err});
    end
    rst_n = 1'b1;
    // Stray line/data activity before any frame start must be ignored.
    tick(0, 0, 0, 0, 0); tick(0, 1, 1, 0, 0); tick(0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0);
    checks++;
    if ({fval_out, lval_out, dval_out, pixel_out, protocol_err, line_err} !== '0) begin
      errors++; $display("FAIL unarmed_idle got %h want 0", {fval_out, lval_out, dval_out, pixel_out, protocol_err, line_err});
    end
    recs.delete();
  endtask

  task automatic test_hgrad();
    logic [7:0] ep;
    pattern_sel = 2'd0;
    for (int f = 0; f < 2; f++) begin
      frame_begin(1'($urandom_range(0, 1)));
      for (int l = 0; l < V; l++) send_line(H);
      frame_end();
      checks++;
      if (frame_cnt !== 16'(exp_fc)) begin
        errors++; $display("FAIL hgrad_frame_cnt got %0d want %0d", frame_cnt, exp_fc);
      end
    end
    foreach (recs[i]) begin
      ep = recs[i].ev ? exp_pixel(recs[i].es, recs[i].ex, recs[i].ey, recs[i].ef) : 8'd0;
      checks++;
      if ({recs[i].av, recs[i].ap} !== {recs[i].ev, ep} ||
          (recs[i].ev && (recs[i].ax !== 16'(recs[i].ex) || recs[i].ay !== 16'(recs[i].ey)))) begin
        errors++;
        $display("FAIL hgrad_pix rec%0d got v=%b p=%0d x=%0d y=%0d want v=%b p=%0d x=%0d y=%0d",
                 i, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay, recs[i].ev, ep, recs[i].ex, recs[i].ey);
      end
    end
    recs.delete();
    checks++;
    if ({line_err, frame_err, protocol_err} !== 3'b000) begin
      errors++; $display("FAIL hgrad_errors got %b want 000", {line_err, frame_err, protocol_err});
    end
  endtask

  task automatic test_bars_check();
    logic [7:0] ep;
    for (int s = 2; s < 4; s++) begin
      pattern_sel = 2'(s);
      frame_begin(1'($urandom_range(0, 1)));
      for (int l = 0; l < V; l++) send_line(H);
      frame_end();
    end
    foreach (recs[i]) begin
      ep = recs[i].ev ? exp_pixel(recs[i].es, recs[i].ex, recs[i].ey, recs[i].ef) : 8'd0;
      checks++;
      if ({recs[i].av, recs[i].ap} !== {recs[i].ev, ep} ||
          (recs[i].ev && (recs[i].ax !== 16'(recs[i].ex) || recs[i].ay !== 16'(recs[i].ey)))) begin
        errors++;
        $display("FAIL barchk_pix rec%0d sel=%0d got v=%b p=%0d x=%0d y=%0d want v=%b p=%0d x=%0d y=%0d",
                 i, recs[i].es, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay, recs[i].ev, ep, recs[i].ex, recs[i].ey);
      end
    end
    recs.delete();
  endtask

  task automatic test_errors();
    pattern_sel = 2'd0;
    frame_begin(1);
    send_line(H);
    checks++;
    if (line_err !== 1'b0) begin errors++; $display("FAIL line_err_clean got %b want 0", line_err); end
    send_line(H - 1);
    checks++;
    if (line_err !== 1'b1) begin errors++; $display("FAIL line_err_short got %b want 1", line_err); end
    send_line(H); send_line(H);
    frame_end();
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_4lines got %b want 0", frame_err); end
    clear_pulse();
    checks++;
    if (line_err !== 1'b0) begin errors++; $display("FAIL line_err_cleared got %b want 0", line_err); end
    frame_begin(1);
    for (int l = 0; l < V - 1; l++) send_line(H);
    frame_end();
    checks++;
    if ({frame_err, line_err} !== 2'b10) begin
      errors++; $display("FAIL frame_err_3lines got %b want 10", {frame_err, line_err});
    end
    clear_pulse();
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_cleared got %b want 0", frame_err); end
    frame_begin(1);
    send_line(H);
    clr_on_fall = 1'b1;
    send_line(H - 1);
    clr_on_fall = 1'b0;
    checks++;
    if (line_err !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b want 1", line_err); end
    send_line(H); send_line(H);
    frame_end();
    clear_pulse();
    checks++;
    if ({line_err, frame_err, protocol_err} !== 3'b000) begin
      errors++; $display("FAIL errors_final_clear got %b want 000", {line_err, frame_err, protocol_err});
    end
    recs.delete();
  endtask

  task automatic test_protocol();
    logic [7:0] ep;
    pattern_sel = 2'd1;
    frame_begin(1);
    send_line(H);
    tick(1, 0, 1, 0, 0);
    checks++;
    if ({protocol_err, dval_out, pixel_out} !== {1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL proto_dval got err=%b dv=%b p=%0d want err=1 dv=0 p=0", protocol_err, dval_out, pixel_out);
    end
    checks++;
    if (x_out !== 16'(H)) begin errors++; $display("FAIL proto_x_hold got %0d want %0d", x_out, H); end
    for (int l = 1; l < V; l++) send_line(H);
    frame_end();
    foreach (recs[i]) begin
      ep = recs[i].ev ? exp_pixel(recs[i].es, recs[i].ex, recs[i].ey, recs[i].ef) : 8'd0;
      checks++;
      if ({recs[i].av, recs[i].ap} !== {recs[i].ev, ep} ||
          (recs[i].ev && (recs[i].ax !== 16'(recs[i].ex) || recs[i].ay !== 16'(recs[i].ey)))) begin
        errors++;
        $display("FAIL proto_pix rec%0d got v=%b p=%0d x=%0d y=%0d want v=%b p=%0d x=%0d y=%0d",
                 i, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay, recs[i].ev, ep, recs[i].ex, recs[i].ey);
      end
    end
    recs.delete();
    checks++;
    if ({line_err, frame_err} !== 2'b00) begin
      errors++; $display("FAIL proto_geometry got %b want 00", {line_err, frame_err});
    end
    clear_pulse();
    checks++;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL proto_cleared got %b want 0", protocol_err); end
    tick(0, 1, 0, 0, 0);
    checks++;
    if ({protocol_err, lval_out} !== 2'b10) begin
      errors++; $display("FAIL proto_lval got err=%b lv=%b want err=1 lv=0", protocol_err, lval_out);
    end
    tick(0, 0, 0, 0, 0);
    clear_pulse();
    recs.delete();
  endtask

  task automatic test_sel_change();
    logic [7:0] ep;
    pattern_sel = 2'd0;
    frame_begin(1);
    send_line(H);
    pattern_sel = 2'd3;
    for (int l = 1; l < V; l++) send_line(H);
    frame_end();
    frame_begin(0);
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    foreach (recs[i]) begin
      ep = recs[i].ev ? exp_pixel(recs[i].es, recs[i].ex, recs[i].ey, recs[i].ef) : 8'd0;
      checks++;
      if ({recs[i].av, recs[i].ap} !== {recs[i].ev, ep} ||
          (recs[i].ev && (recs[i].ax !== 16'(recs[i].ex) || recs[i].ay !== 16'(recs[i].ey)))) begin
        errors++;
        $display("FAIL selchg_pix rec%0d sel=%0d got v=%b p=%0d x=%0d y=%0d want v=%b p=%0d x=%0d y=%0d",
                 i, recs[i].es, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay, recs[i].ev, ep, recs[i].ex, recs[i].ey);
      end
    end
    recs.delete();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] ep;
    pattern_sel = 2'd0;
    frame_begin(1);
    tick(1, 1, 1, 1, 0); tick(1, 1, 1, 1, 1);
    recs.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fval_out, lval_out, dval_out, pixel_out, x_out, y_out} !== '0) begin
      errors++; $display("FAIL async_reset_outputs got %h want 0", {fval_out, lval_out, dval_out, pixel_out, x_out, y_out});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_frame_cnt got %0d want 0", frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 0;
    @(posedge clk); #1;
    // Remainder of the interrupted frame, including a short line and a protocol slip.
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    foreach (recs[i]) begin
      checks++;
      if ({recs[i].af, recs[i].al, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay} !== '0) begin
        errors++; $display("FAIL unarmed_out rec%0d got f=%b l=%b v=%b p=%0d x=%0d y=%0d want all 0",
                           i, recs[i].af, recs[i].al, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay);
      end
    end
    recs.delete();
    checks++;
    if ({frame_cnt, line_err, frame_err, protocol_err} !== '0) begin
      errors++; $display("FAIL unarmed_status got %h want 0", {frame_cnt, line_err, frame_err, protocol_err});
    end
    frame_begin(1'($urandom_range(0, 1)));
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    foreach (recs[i]) begin
      ep = recs[i].ev ? exp_pixel(recs[i].es, recs[i].ex, recs[i].ey, recs[i].ef) : 8'd0;
      checks++;
      if ({recs[i].av, recs[i].ap} !== {recs[i].ev, ep} ||
          (recs[i].ev && (recs[i].ax !== 16'(recs[i].ex) || recs[i].ay !== 16'(recs[i].ey)))) begin
        errors++;
        $display("FAIL rearm_pix rec%0d got v=%b p=%0d x=%0d y=%0d want v=%b p=%0d x=%0d y=%0d",
                 i, recs[i].av, recs[i].ap, recs[i].ax, recs[i].ay, recs[i].ev, ep, recs[i].ex, recs[i].ey);
      end
    end
    recs.delete();
    checks++;
    if ({frame_cnt, line_err, frame_err, protocol_err} !== {16'd1, 3'b000}) begin
      errors++; $display("FAIL rearm_status got cnt=%0d err=%b want cnt=1 err=000",
                         frame_cnt, {line_err, frame_err, protocol_err});
    end
  endtask

  initial begin
    test_reset();
    test_hgrad();
    test_bars_check();
    test_errors();
    test_protocol();
    test_sel_change();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
